// File: rtl/sc_game_pkg.sv
// Shared types and constants for the RoadFighter game-time counter.
// Holds the FSM state encoding, zone indices and the prescaler width helper.
package sc_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] ZONE_0 = 3'd0;
    localparam logic [2:0] ZONE_1 = 3'd1;
    localparam logic [2:0] ZONE_2 = 3'd2;
    localparam logic [2:0] ZONE_3 = 3'd3;
    localparam logic [2:0] ZONE_4 = 3'd4;

    // Bits needed to hold 0..div-1; never less than one bit.
    function automatic int presc_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sc_bin2bcd_99.sv
// Combinational 7-bit binary to two BCD digits for the 7-segment driver.
// Results are meaningful for inputs 0..99.
module sc_bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    assign tens  = 4'(bin / 7'd10);
    assign units = 4'(bin - 7'(tens) * 7'd10);

endmodule

// File: rtl/sc_game_timer_zoned.sv
// Game-time counter: prescaled tick, up/down time count with start/pause/clear,
// terminal DONE, speed/fuel zone classification and BCD presentation.
module sc_game_timer_zoned
    import sc_game_pkg::*;
#(
    parameter int PRESCALE_DIV = 50000000,
    parameter int TIME_WIDTH   = 8,
    parameter int LIMIT        = 60,
    parameter int COUNT_DOWN   = 0,
    parameter int ZONE1_END    = 11,
    parameter int ZONE2_END    = 18,
    parameter int ZONE3_END    = 33,
    parameter int ZONE4_END    = 41
) (
    input  logic                  SC_RegGENERAL_CLOCK_50,
    input  logic                  SC_RegGENERAL_RESET_InHigh,
    input  logic                  SC_RegGENERAL_START_InHigh,
    input  logic                  SC_RegGENERAL_PAUSE_InHigh,
    input  logic                  SC_RegGENERAL_CLEAR_InHigh,
    output logic [TIME_WIDTH-1:0] SC_RegGENERAL_data_OutBUS,
    output logic                  SC_RegGENERAL_TICK_Out,
    output logic [2:0]            SC_RegGENERAL_ZONE_OutBUS,
    output logic [3:0]            SC_RegGENERAL_BCDTENS_OutBUS,
    output logic [3:0]            SC_RegGENERAL_BCDUNITS_OutBUS,
    output logic                  SC_RegGENERAL_RUNNING_Out,
    output logic                  SC_RegGENERAL_DONE_Out
);

    localparam int PW = presc_width(PRESCALE_DIV);
    localparam logic [PW-1:0]         PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]         PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE_DIV - 1);
    localparam logic [TIME_WIDTH-1:0] TIME_ONE   = TIME_WIDTH'(1);
    localparam logic [TIME_WIDTH-1:0] TIME_LIMIT = TIME_WIDTH'(LIMIT);
    localparam logic [TIME_WIDTH-1:0] INIT_TIME  = (COUNT_DOWN != 0) ? TIME_LIMIT : {TIME_WIDTH{1'b0}};
    localparam logic [TIME_WIDTH-1:0] END_TIME   = (COUNT_DOWN != 0) ? {TIME_WIDTH{1'b0}} : TIME_LIMIT;

    if ((LIMIT < 1) || (LIMIT > 99)) begin : g_bad_limit_range
        $error("sc_game_timer_zoned: LIMIT must be within 1..99");
    end
    if ((TIME_WIDTH < 31) && (LIMIT >= (1 << TIME_WIDTH))) begin : g_bad_limit_width
        $error("sc_game_timer_zoned: LIMIT does not fit TIME_WIDTH");
    end
    if (PRESCALE_DIV < 2) begin : g_bad_prescale
        $error("sc_game_timer_zoned: PRESCALE_DIV must be at least 2");
    end
    if (!((ZONE1_END < ZONE2_END) && (ZONE2_END < ZONE3_END) && (ZONE3_END < ZONE4_END))) begin : g_bad_zones
        $error("sc_game_timer_zoned: zone thresholds must be strictly increasing");
    end

    state_t                  state_r, state_s;
    logic [PW-1:0]           presc_r, presc_s;
    logic [TIME_WIDTH-1:0]   time_r, time_s;
    logic [TIME_WIDTH-1:0]   time_step_s;
    logic                    tick_r, tick_s;
    logic                    running_r, done_r;
    logic [TIME_WIDTH-1:0]   elapsed_s;
    logic [31:0]             elapsed_ext_s;
    logic [2:0]              zone_s;
    logic [3:0]              bcd_tens_s, bcd_units_s;

    assign time_step_s = (COUNT_DOWN != 0) ? (time_r - TIME_ONE) : (time_r + TIME_ONE);

    // Next-state, prescaler and time update; CLEAR outranks PAUSE outranks START.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        time_s  = time_r;
        tick_s  = 1'b0;
        if (SC_RegGENERAL_CLEAR_InHigh) begin
            state_s = ST_IDLE;
            presc_s = PRESC_ZERO;
            time_s  = INIT_TIME;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!SC_RegGENERAL_PAUSE_InHigh && SC_RegGENERAL_START_InHigh) begin
                        state_s = ST_RUN;
                        presc_s = PRESC_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with PAUSE still lands; reaching END wins over PAUSE.
                    if (presc_r == PRESC_LAST) begin
                        presc_s = PRESC_ZERO;
                        time_s  = time_step_s;
                        tick_s  = 1'b1;
                        if (time_step_s == END_TIME) begin
                            state_s = ST_DONE;
                        end else if (SC_RegGENERAL_PAUSE_InHigh) begin
                            state_s = ST_PAUSED;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                        if (SC_RegGENERAL_PAUSE_InHigh) begin
                            state_s = ST_PAUSED;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end
                ST_PAUSED: begin
                    // Prescaler is deliberately held so a resume finishes the partial tick.
                    if (!SC_RegGENERAL_PAUSE_InHigh && SC_RegGENERAL_START_InHigh) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = PRESC_ZERO;
                    time_s  = INIT_TIME;
                end
            endcase
        end
    end

    // State, prescaler, time and registered status outputs.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            time_r    <= INIT_TIME;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            time_r    <= time_s;
            tick_r    <= tick_s;
            running_r <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign elapsed_s     = (COUNT_DOWN != 0) ? (TIME_LIMIT - time_r) : time_r;
    assign elapsed_ext_s = 32'(elapsed_s);

    // Zone is the first threshold the elapsed time is still below.
    always_comb begin
        zone_s = ZONE_4;
        if (elapsed_ext_s < 32'(ZONE1_END)) begin
            zone_s = ZONE_0;
        end else if (elapsed_ext_s < 32'(ZONE2_END)) begin
            zone_s = ZONE_1;
        end else if (elapsed_ext_s < 32'(ZONE3_END)) begin
            zone_s = ZONE_2;
        end else if (elapsed_ext_s < 32'(ZONE4_END)) begin
            zone_s = ZONE_3;
        end else begin
            zone_s = ZONE_4;
        end
    end

    sc_bin2bcd_99 u_bcd (
        .bin   (7'(time_r)),
        .tens  (bcd_tens_s),
        .units (bcd_units_s)
    );

    assign SC_RegGENERAL_data_OutBUS     = time_r;
    assign SC_RegGENERAL_TICK_Out        = tick_r;
    assign SC_RegGENERAL_ZONE_OutBUS     = zone_s;
    assign SC_RegGENERAL_BCDTENS_OutBUS  = bcd_tens_s;
    assign SC_RegGENERAL_BCDUNITS_OutBUS = bcd_units_s;
    assign SC_RegGENERAL_RUNNING_Out     = running_r;
    assign SC_RegGENERAL_DONE_Out        = done_r;

endmodule

// File: tb/tb_sc_game_timer_zoned.sv
// Self-checking bench: directed scenarios plus randomized control against a
// behavioural model, for an up-counting and a down-counting instance.
module tb_sc_game_timer_zoned;

    localparam int DIV = 4;
    localparam int LIM = 12;

    logic clk = 1'b0;
    logic rst, start, pause, clear;

    logic [7:0] data_u, data_d;
    logic       tick_u, tick_d, running_u, running_d, done_u, done_d;
    logic [2:0] zone_u, zone_d;
    logic [3:0] tens_u, tens_d, units_u, units_d;

    int nvec = 0;
    int nerr = 0;
    int th [4] = '{3, 5, 8, 10};

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_mode [2];
    int m_time [2];
    int m_cnt  [2];
    bit m_tick [2];

    always #5 clk = ~clk;

    sc_game_timer_zoned #(.PRESCALE_DIV(DIV), .TIME_WIDTH(8), .LIMIT(LIM), .COUNT_DOWN(0),
        .ZONE1_END(3), .ZONE2_END(5), .ZONE3_END(8), .ZONE4_END(10)) dut_up (
        .SC_RegGENERAL_CLOCK_50        (clk),
        .SC_RegGENERAL_RESET_InHigh    (rst),
        .SC_RegGENERAL_START_InHigh    (start),
        .SC_RegGENERAL_PAUSE_InHigh    (pause),
        .SC_RegGENERAL_CLEAR_InHigh    (clear),
        .SC_RegGENERAL_data_OutBUS     (data_u),
        .SC_RegGENERAL_TICK_Out        (tick_u),
        .SC_RegGENERAL_ZONE_OutBUS     (zone_u),
        .SC_RegGENERAL_BCDTENS_OutBUS  (tens_u),
        .SC_RegGENERAL_BCDUNITS_OutBUS (units_u),
        .SC_RegGENERAL_RUNNING_Out     (running_u),
        .SC_RegGENERAL_DONE_Out        (done_u)
    );

    sc_game_timer_zoned #(.PRESCALE_DIV(DIV), .TIME_WIDTH(8), .LIMIT(LIM), .COUNT_DOWN(1),
        .ZONE1_END(3), .ZONE2_END(5), .ZONE3_END(8), .ZONE4_END(10)) dut_dn (
        .SC_RegGENERAL_CLOCK_50        (clk),
        .SC_RegGENERAL_RESET_InHigh    (rst),
        .SC_RegGENERAL_START_InHigh    (start),
        .SC_RegGENERAL_PAUSE_InHigh    (pause),
        .SC_RegGENERAL_CLEAR_InHigh    (clear),
        .SC_RegGENERAL_data_OutBUS     (data_d),
        .SC_RegGENERAL_TICK_Out        (tick_d),
        .SC_RegGENERAL_ZONE_OutBUS     (zone_d),
        .SC_RegGENERAL_BCDTENS_OutBUS  (tens_d),
        .SC_RegGENERAL_BCDUNITS_OutBUS (units_d),
        .SC_RegGENERAL_RUNNING_Out     (running_d),
        .SC_RegGENERAL_DONE_Out        (done_d)
    );

    // Zone = how many thresholds the elapsed time has reached.
    function automatic int exp_zone(input int e);
        int z = 0;
        for (int i = 0; i < 4; i++) if (e >= th[i]) z++;
        return z;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear_start();
        clear = 1'b1; cyc(); clear = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_time[k] = (k == 1) ? LIM : 0;
            m_cnt[k]  = 0;
            m_tick[k] = 1'b0;
        end
    endtask

    // One clock edge of the game-timer rules; the run counter counts cycles spent running.
    task automatic model_step(input bit c, input bit p, input bit s);
        for (int k = 0; k < 2; k++) begin
            m_tick[k] = 1'b0;
            if (c) begin
                m_mode[k] = M_IDLE;
                m_time[k] = (k == 1) ? LIM : 0;
                m_cnt[k]  = 0;
            end else if (m_mode[k] == M_IDLE) begin
                if (!p && s) begin m_mode[k] = M_RUN; m_cnt[k] = 0; end
            end else if (m_mode[k] == M_RUN) begin
                m_cnt[k]++;
                if (m_cnt[k] == DIV) begin
                    m_cnt[k]  = 0;
                    m_time[k] = m_time[k] + ((k == 1) ? -1 : 1);
                    m_tick[k] = 1'b1;
                    if (m_time[k] == ((k == 1) ? 0 : LIM)) m_mode[k] = M_DONE;
                    else if (p) m_mode[k] = M_PAUSED;
                end else if (p) begin
                    m_mode[k] = M_PAUSED;
                end
            end else if (m_mode[k] == M_PAUSED) begin
                if (!p && s) m_mode[k] = M_RUN;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        #2;
        nvec++; if (data_u !== 8'd0) begin nerr++; $display("FAIL reset_data_up got %0d want 0", data_u); end
        nvec++; if (data_d !== 8'd12) begin nerr++; $display("FAIL reset_data_dn got %0d want 12", data_d); end
        cyc(); cyc(); rst = 1'b0; cyc();
        nvec++; if ({tick_u, running_u, done_u, zone_u} !== 6'd0) begin nerr++; $display("FAIL reset_flags_up got %b want 0", {tick_u, running_u, done_u, zone_u}); end
        nvec++; if ({tens_u, units_u} !== 8'h00) begin nerr++; $display("FAIL reset_bcd_up got %h want 00", {tens_u, units_u}); end
        nvec++; if ({tens_d, units_d, zone_d} !== {8'h12, 3'd0}) begin nerr++; $display("FAIL reset_bcd_zone_dn got %h/%0d want 12/0", {tens_d, units_d}, zone_d); end
    endtask

    task automatic test_count_and_zones();
        pulse_clear_start();
        nvec++; if (running_u !== 1'b1 || data_u !== 8'd0) begin nerr++; $display("FAIL start_up got run=%b t=%0d want 1/0", running_u, data_u); end
        for (int t = 1; t <= LIM; t++) begin
            repeat (DIV - 1) begin
                cyc();
                nvec++; if (tick_u !== 1'b0) begin nerr++; $display("FAIL early_tick t=%0d got 1 want 0", t); end
            end
            cyc();
            nvec++; if (tick_u !== 1'b1 || data_u !== 8'(t)) begin nerr++; $display("FAIL tick_up got tick=%b t=%0d want 1/%0d", tick_u, data_u, t); end
            nvec++; if (done_u !== (t == LIM) || done_d !== (t == LIM)) begin nerr++; $display("FAIL done t=%0d got %b%b want %0d", t, done_u, done_d, t == LIM); end
            nvec++; if (zone_u !== 3'(exp_zone(t))) begin nerr++; $display("FAIL zone_up t=%0d got %0d want %0d", t, zone_u, exp_zone(t)); end
            nvec++; if (tens_u !== 4'(t / 10) || units_u !== 4'(t % 10)) begin nerr++; $display("FAIL bcd_up t=%0d got %0d%0d", t, tens_u, units_u); end
            nvec++; if (data_d !== 8'(LIM - t) || zone_d !== 3'(exp_zone(t))) begin nerr++; $display("FAIL down t=%0d got %0d z%0d want %0d z%0d", t, data_d, zone_d, LIM - t, exp_zone(t)); end
        end
        repeat (20) begin
            cyc();
            nvec++; if (data_u !== 8'd12 || tick_u !== 1'b0 || done_u !== 1'b1 || data_d !== 8'd0) begin nerr++; $display("FAIL hold_done got %0d tick=%b done=%b dn=%0d want 12/0/1/0", data_u, tick_u, done_u, data_d); end
        end
    endtask

    task automatic test_pause();
        pulse_clear_start();
        repeat (8) cyc();
        nvec++; if (data_u !== 8'd2) begin nerr++; $display("FAIL pause_pre got %0d want 2", data_u); end
        cyc();
        pause = 1'b1;
        cyc();
        nvec++; if (running_u !== 1'b0 || data_u !== 8'd2) begin nerr++; $display("FAIL pause_enter got run=%b t=%0d want 0/2", running_u, data_u); end
        repeat (9) begin
            cyc();
            nvec++; if (data_u !== 8'd2 || tick_u !== 1'b0) begin nerr++; $display("FAIL paused_frozen got %0d tick=%b want 2/0", data_u, tick_u); end
        end
        pause = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        nvec++; if (running_u !== 1'b1) begin nerr++; $display("FAIL resume got run=%b want 1", running_u); end
        cyc();
        nvec++; if (tick_u !== 1'b0) begin nerr++; $display("FAIL resume_early got tick=1 want 0"); end
        cyc();
        nvec++; if (tick_u !== 1'b1 || data_u !== 8'd3) begin nerr++; $display("FAIL resume_tick got %b/%0d want 1/3", tick_u, data_u); end
        repeat (3) cyc();
        nvec++; if (data_u !== 8'd3) begin nerr++; $display("FAIL no_extra_tick got %0d want 3", data_u); end
        cyc();
        nvec++; if (tick_u !== 1'b1 || data_u !== 8'd4) begin nerr++; $display("FAIL next_tick got %b/%0d want 1/4", tick_u, data_u); end
    endtask

    task automatic test_clear_on_tick();
        pulse_clear_start();
        repeat (28) cyc();
        nvec++; if (data_u !== 8'd7) begin nerr++; $display("FAIL clr_pre got %0d want 7", data_u); end
        repeat (3) cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        nvec++; if (data_u !== 8'd0 || tick_u !== 1'b0 || running_u !== 1'b0) begin nerr++; $display("FAIL clr_tick got %0d tick=%b run=%b want 0/0/0", data_u, tick_u, running_u); end
        nvec++; if (data_d !== 8'd12) begin nerr++; $display("FAIL clr_dn got %0d want 12", data_d); end
        repeat (5) begin
            cyc();
            nvec++; if (data_u !== 8'd0 || tick_u !== 1'b0) begin nerr++; $display("FAIL clr_idle got %0d/%b want 0/0", data_u, tick_u); end
        end
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) begin
            cyc();
            nvec++; if (tick_u !== 1'b0) begin nerr++; $display("FAIL restart_early got 1 want 0"); end
        end
        cyc();
        nvec++; if (tick_u !== 1'b1 || data_u !== 8'd1) begin nerr++; $display("FAIL restart_tick got %b/%0d want 1/1", tick_u, data_u); end
    endtask

    task automatic test_async_reset();
        pulse_clear_start();
        repeat (22) cyc();
        nvec++; if (data_u !== 8'd5) begin nerr++; $display("FAIL ar_pre got %0d want 5", data_u); end
        #3 rst = 1'b1;
        #1;
        nvec++; if (data_u !== 8'd0 || {tick_u, running_u, done_u, zone_u} !== 6'd0) begin nerr++; $display("FAIL async_reset_up got %0d/%b want 0/0", data_u, {tick_u, running_u, done_u, zone_u}); end
        nvec++; if ({tens_u, units_u} !== 8'h00 || data_d !== 8'd12) begin nerr++; $display("FAIL async_reset_bcd got %h dn=%0d want 00/12", {tens_u, units_u}, data_d); end
        cyc(); cyc(); rst = 1'b0;
        repeat (10) begin
            cyc();
            nvec++; if (data_u !== 8'd0 || tick_u !== 1'b0 || running_u !== 1'b0) begin nerr++; $display("FAIL ar_idle got %0d/%b/%b want 0/0/0", data_u, tick_u, running_u); end
        end
        start = 1'b1; cyc(); start = 1'b0;
        repeat (DIV) cyc();
        nvec++; if (tick_u !== 1'b1 || data_u !== 8'd1) begin nerr++; $display("FAIL ar_restart got %b/%0d want 1/1", tick_u, data_u); end
    endtask

    task automatic test_random();
        logic [7:0] g_data;
        logic [2:0] g_zone;
        logic [7:0] g_bcd;
        logic       g_tick, g_run, g_done;
        int         el;
        rst = 1'b1; clear = 1'b0; pause = 1'b0; start = 1'b0;
        cyc(); rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            clear = ($urandom_range(0, 199) < 2);
            pause = ($urandom_range(0, 99) < 8);
            start = ($urandom_range(0, 99) < 40);
            @(posedge clk);
            model_step(clear, pause, start);
            #1;
            for (int k = 0; k < 2; k++) begin
                g_data = (k == 1) ? data_d : data_u;
                g_tick = (k == 1) ? tick_d : tick_u;
                g_run  = (k == 1) ? running_d : running_u;
                g_done = (k == 1) ? done_d : done_u;
                g_zone = (k == 1) ? zone_d : zone_u;
                g_bcd  = (k == 1) ? {tens_d, units_d} : {tens_u, units_u};
                el = (k == 1) ? LIM - m_time[k] : m_time[k];
                nvec++; if (g_data !== 8'(m_time[k])) begin nerr++; $display("FAIL rand_data i%0d n%0d got %0d want %0d", k, n, g_data, m_time[k]); end
                nvec++; if (g_tick !== m_tick[k]) begin nerr++; $display("FAIL rand_tick i%0d n%0d got %b want %b", k, n, g_tick, m_tick[k]); end
                nvec++; if (g_run !== (m_mode[k] == M_RUN)) begin nerr++; $display("FAIL rand_running i%0d n%0d got %b want %0d", k, n, g_run, m_mode[k] == M_RUN); end
                nvec++; if (g_done !== (m_mode[k] == M_DONE)) begin nerr++; $display("FAIL rand_done i%0d n%0d got %b want %0d", k, n, g_done, m_mode[k] == M_DONE); end
                nvec++; if (g_zone !== 3'(exp_zone(el))) begin nerr++; $display("FAIL rand_zone i%0d n%0d got %0d want %0d", k, n, g_zone, exp_zone(el)); end
                nvec++; if (g_bcd !== {4'(m_time[k] / 10), 4'(m_time[k] % 10)}) begin nerr++; $display("FAIL rand_bcd i%0d n%0d got %h want %0d", k, n, g_bcd, m_time[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_and_zones();
        test_pause();
        test_clear_on_tick();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
